hazard_unit: RTL
================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter MEM_LAT, default 3, data-memory access latency in cycles; legal range 1..15.
REQ-002 Parameter CNT_W, default 16, width of the statistics counters.
REQ-003 The port list SHALL be exactly as follows:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- id_rs  in  5  ID-stage source register 1.
- id_rt  in  5  ID-stage source register 2.
- id_use_rs  in  1  ID instruction reads id_rs.
- id_use_rt  in  1  ID instruction reads id_rt.
- ex_rd  in  5  EX-stage destination register.
- ex_mem_read  in  1  EX instruction is a load.
- mem_req  in  1  single-cycle pulse; MEM stage issues a data-memory access.
- branch_taken  in  1  branch resolved taken in ID.
- stall_req  out  1  pipeline stall request; drives the stall-vector generator.
- bubble  out  1  insert a NOP into ID/EX.
- flush  out  1  squash the IF/ID instruction.
- mem_busy  out  1  FSM is in MEM_WAIT.
- err  out  1  sticky protocol-error flag.
- stall_cycles  out  CNT_W  saturating count of cycles with stall_req=1.
- lu_events  out  CNT_W  saturating count of load-use hazards.

Function
REQ-004 lu_hit SHALL be high iff ex_mem_read=1, ex_rd!=0, and either (id_use_rs=1 and id_rs==ex_rd) or (id_use_rt=1 and id_rt==ex_rd).
REQ-005 FSM SHALL have two states, IDLE and MEM_WAIT, plus a 4-bit down-counter wcnt.
REQ-006 In IDLE with mem_req=1 and MEM_LAT>1: next state MEM_WAIT, wcnt<=MEM_LAT-1.
REQ-007 With MEM_LAT=1, mem_req SHALL cause no state change.
REQ-008 In MEM_WAIT, wcnt SHALL decrement every cycle; when wcnt==1, next state IDLE.
REQ-009 stall_req SHALL be the combinational OR of (state==MEM_WAIT) and (state==IDLE and lu_hit).
REQ-010 Consequence of REQ-006 to REQ-009: after the mem_req cycle, stall_req is held for exactly MEM_LAT-1 consecutive cycles.
REQ-011 bubble SHALL equal (state==IDLE and lu_hit); it is never asserted in MEM_WAIT.
REQ-012 lu_hit SHALL be ignored in MEM_WAIT; it is re-evaluated on the first IDLE cycle.
REQ-013 mem_req and lu_hit together in IDLE: stall_req=1 and bubble=1 that cycle, then MEM_WAIT per REQ-006.
REQ-014 flush SHALL equal branch_taken and not stall_req; a branch held under stall flushes only when the stall releases.
REQ-015 mem_req=1 while in MEM_WAIT SHALL set err=1; the request is otherwise ignored (no reload of wcnt).
REQ-016 err SHALL stay 1 until reset.
REQ-017 stall_cycles SHALL increment on every clock edge where stall_req=1, saturating at 2^CNT_W-1.
REQ-018 lu_events SHALL increment on every clock edge where bubble=1, saturating at 2^CNT_W-1.
REQ-019 mem_busy SHALL be high iff state==MEM_WAIT.
REQ-020 All state SHALL be updated on the rising edge of clk only; outputs stall_req, bubble and flush are combinational from state and inputs.

Reset
REQ-021 reset=1 at a clock edge SHALL set state=IDLE, wcnt=0, err=0, stall_cycles=0 and lu_events=0.
REQ-022 While reset=1, stall_req, bubble and flush SHALL be 0, regardless of inputs.
REQ-023 Reset asserted mid-MEM_WAIT SHALL abort the wait; the first post-reset cycle is IDLE with stall_req=0 unless lu_hit.

Structure
REQ-024 State encoding (IDLE=0, MEM_WAIT=1) and the register-index width constant (5) SHALL live in the shared pipeline package.
REQ-025 Package constant REG_ZERO=5'd0 SHALL be used for the ex_rd!=0 check.
REQ-026 The lu_hit comparator SHALL be a sub-module, hazard_cmp: pure combinational, inputs id_rs, id_rt, id_use_rs, id_use_rt, ex_rd, ex_mem_read; output lu_hit.
REQ-027 stall_req SHALL connect directly to the stall-vector generator's signal input.

Verification (MEM_LAT=3, CNT_W=16)
REQ-028 Load-use: ex_mem_read=1, ex_rd=8, id_rs=8, id_use_rs=1 for one cycle -> stall_req=1 and bubble=1 that cycle; lu_events=1 and stall_cycles=1 afterwards.
REQ-029 Register zero: same as REQ-028 but ex_rd=0, id_rs=0 -> stall_req=0, bubble=0, counters unchanged.
REQ-030 Memory wait: one-cycle mem_req pulse at cycle t -> mem_busy=1 and stall_req=1 in cycles t+1 and t+2; both 0 at t+3; stall_cycles=2.
REQ-031 Overlap: during MEM_WAIT, lu_hit=1 and mem_req=1 -> bubble=0 and err=1; after return to IDLE with lu_hit still 1 -> bubble=1 for one cycle.
REQ-032 Branch under stall: branch_taken=1 held through a mem_req wait -> flush=0 in t+1 and t+2, flush=1 at t+3.
REQ-033 Reset mid-wait: reset at t+1 -> at t+2 state=IDLE, stall_req=0, err=0, counters=0.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions used by the hazard detection block and its comparator.
package hazard_unit_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/hazard_unit_cmp.sv
// Load-use comparator: flags an ID-stage read of a register still being loaded in EX.
module hazard_cmp
  import hazard_unit_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  output logic             lu_hit
);

  always_comb begin
    lu_hit = ex_mem_read && (ex_rd != REG_ZERO) &&
             ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use bubbles, data-memory wait stalls, branch flush and stall statistics.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned MEM_LAT = 3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             mem_req,
  input  logic             branch_taken,
  output logic             stall_req,
  output logic             bubble,
  output logic             flush,
  output logic             mem_busy,
  output logic             err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] lu_events
);

  localparam bit         LAT_MULTI  = (MEM_LAT > 1);
  localparam logic [3:0] LAT_RELOAD = 4'(MEM_LAT - 1);

  hz_state_e        state_q, state_d;
  logic [3:0]       wcnt_q, wcnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] lu_events_q, lu_events_d;
  logic             lu_hit;

  hazard_cmp u_cmp (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .lu_hit      (lu_hit)
  );

  always_comb begin
    state_d        = state_q;
    wcnt_d         = wcnt_q;
    err_d          = err_q;
    stall_cycles_d = stall_cycles_q;
    lu_events_d    = lu_events_q;
    stall_req      = 1'b0;
    bubble         = 1'b0;
    flush          = 1'b0;

    // Outputs are forced low during reset so no stale state leaks into the pipeline.
    if (!reset) begin
      bubble    = (state_q == IDLE) && lu_hit;
      stall_req = (state_q == MEM_WAIT) || bubble;
      flush     = branch_taken && !stall_req;
    end

    case (state_q)
      IDLE: begin
        if (mem_req && LAT_MULTI) begin
          state_d = MEM_WAIT;
          wcnt_d  = LAT_RELOAD;
        end
      end
      MEM_WAIT: begin
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q == 4'd1) state_d = IDLE;
        if (mem_req) err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (stall_req && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
    if (bubble && (lu_events_q != '1))       lu_events_d    = lu_events_q + CNT_W'(1);

    if (reset) begin
      state_d        = IDLE;
      wcnt_d         = '0;
      err_d          = 1'b0;
      stall_cycles_d = '0;
      lu_events_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    state_q        <= state_d;
    wcnt_q         <= wcnt_d;
    err_q          <= err_d;
    stall_cycles_q <= stall_cycles_d;
    lu_events_q    <= lu_events_d;
  end

  assign mem_busy     = (state_q == MEM_WAIT);
  assign err          = err_q;
  assign stall_cycles = stall_cycles_q;
  assign lu_events    = lu_events_q;

endmodule
